// File: rtl/game_scheduler.sv
// game_scheduler: frame-level sequencer producing game state, scroll offset,
// frame ticks, flap pulses and per-frame collision detection.
module game_scheduler #(
  parameter int H_TOT        = 800,
  parameter int V_TOT        = 525,
  parameter int H_VIS        = 640,
  parameter int V_VIS        = 480,
  parameter int SCROLL_MOD   = 640,
  parameter int SCROLL_STEP  = 2,
  parameter int DEATH_FRAMES = 60
) (
  input  logic                          iClk,
  input  logic                          iRstN,
  input  logic [$clog2(H_TOT)-1:0]      iCountH,
  input  logic [$clog2(V_TOT)-1:0]      iCountV,
  input  logic                          iDrawBird,
  input  logic                          iDrawPipe,
  input  logic                          iDrawGround,
  input  logic                          iFlap,
  output logic [1:0]                    oState,
  output logic [$clog2(SCROLL_MOD)-1:0] oScrollX,
  output logic                          oFrameTick,
  output logic                          oFlapFrame,
  output logic                          oCollision,
  output logic [15:0]                   oFrames
);
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int SW = $clog2(SCROLL_MOD);
  localparam int DW = $clog2(DEATH_FRAMES + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DYING = 2'b10, OVER = 2'b11} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   scroll_q, scroll_d;
  logic [15:0]     frames_q, frames_d;
  logic [DW-1:0]   death_q, death_d;
  logic            tick_q, tick_d;
  logic            flapf_q, flapf_d;
  logic            coll_q, coll_d;
  logic            pend_q, pend_d;
  logic            flap_prev_q, flap_prev_d;
  logic            eof, hit, rise;
  logic [SW:0]     scroll_sum;
  logic [SW-1:0]   scroll_adv;

  always_comb begin
    eof        = (iCountH == HW'(H_TOT - 1)) && (iCountV == VW'(V_TOT - 1));
    hit        = (iCountH < HW'(H_VIS)) && (iCountV < VW'(V_VIS)) && iDrawBird && (iDrawPipe || iDrawGround);
    rise       = iFlap && !flap_prev_q;
    // one extra bit so the sum can never wrap before the modulus compare
    scroll_sum = {1'b0, scroll_q} + (SW+1)'(SCROLL_STEP);
    scroll_adv = (scroll_sum >= (SW+1)'(SCROLL_MOD)) ? SW'(scroll_sum - (SW+1)'(SCROLL_MOD)) : scroll_sum[SW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    scroll_d    = scroll_q;
    frames_d    = frames_q;
    death_d     = death_q;
    tick_d      = eof;
    flapf_d     = 1'b0;
    flap_prev_d = iFlap;
    // collision and flap state are consumed by the FSM before being cleared at the tick
    coll_d      = eof ? 1'b0 : (coll_q || hit);
    pend_d      = eof ? rise : (pend_q || rise);
    if (eof) begin
      case (state_q)
        IDLE: begin
          scroll_d = scroll_adv;
          if (pend_q) begin
            state_d  = RUN;
            frames_d = 16'd0;
            flapf_d  = 1'b1;
          end
        end
        RUN: begin
          if (coll_q) begin
            state_d = DYING;
            death_d = DW'(DEATH_FRAMES - 1);
          end else begin
            scroll_d = scroll_adv;
            frames_d = (frames_q == 16'hFFFF) ? frames_q : frames_q + 16'd1;
            flapf_d  = pend_q;
          end
        end
        DYING: begin
          if (death_q == '0) state_d = OVER;
          else death_d = death_q - DW'(1);
        end
        OVER: begin
          if (pend_q) begin
            state_d  = IDLE;
            scroll_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q     <= IDLE;
      scroll_q    <= '0;
      frames_q    <= 16'd0;
      death_q     <= '0;
      tick_q      <= 1'b0;
      flapf_q     <= 1'b0;
      coll_q      <= 1'b0;
      pend_q      <= 1'b0;
      flap_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scroll_q    <= scroll_d;
      frames_q    <= frames_d;
      death_q     <= death_d;
      tick_q      <= tick_d;
      flapf_q     <= flapf_d;
      coll_q      <= coll_d;
      pend_q      <= pend_d;
      flap_prev_q <= flap_prev_d;
    end
  end

  assign oState     = state_q;
  assign oScrollX   = scroll_q;
  assign oFrameTick = tick_q;
  assign oFlapFrame = flapf_q;
  assign oCollision = coll_q;
  assign oFrames    = frames_q;
endmodule

// File: tb/tb_game_scheduler.sv
// tb_game_scheduler: directed bench for game_scheduler; pixel counters are
// driven directly so each frame costs only a couple of clocks.
module tb_game_scheduler;
  localparam int H_TOT = 800;
  localparam int V_TOT = 525;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic [9:0]  iCountH = '0;
  logic [9:0]  iCountV = '0;
  logic        iDrawBird = 1'b0;
  logic        iDrawPipe = 1'b0;
  logic        iDrawGround = 1'b0;
  logic        iFlap = 1'b0;
  logic [1:0]  oState;
  logic [9:0]  oScrollX;
  logic        oFrameTick;
  logic        oFlapFrame;
  logic        oCollision;
  logic [15:0] oFrames;

  int checks = 0;
  int failures = 0;

  game_scheduler dut (
    .iClk(iClk), .iRstN(iRstN), .iCountH(iCountH), .iCountV(iCountV),
    .iDrawBird(iDrawBird), .iDrawPipe(iDrawPipe), .iDrawGround(iDrawGround),
    .iFlap(iFlap), .oState(oState), .oScrollX(oScrollX), .oFrameTick(oFrameTick),
    .oFlapFrame(oFlapFrame), .oCollision(oCollision), .oFrames(oFrames)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame();
    iCountH = 10'(H_TOT - 1);
    iCountV = 10'(V_TOT - 1);
    @(negedge iClk);
    iCountH = '0;
    iCountV = '0;
  endtask

  task automatic gap_frame();
    frame();
    @(negedge iClk);
  endtask

  task automatic flap_pulse();
    iFlap = 1'b1;
    @(negedge iClk);
    iFlap = 1'b0;
    @(negedge iClk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(oState), 0);
    chk({tag, "_scroll"}, 32'(oScrollX), 0);
    chk({tag, "_tick"}, 32'(oFrameTick), 0);
    chk({tag, "_flapf"}, 32'(oFlapFrame), 0);
    chk({tag, "_coll"}, 32'(oCollision), 0);
    chk({tag, "_frames"}, 32'(oFrames), 0);
  endtask

  initial begin
    repeat (3) @(negedge iClk);
    chk_all_zero("reset");
    iRstN = 1'b1;
    @(negedge iClk);
    // three attract-mode frames
    for (int i = 0; i < 3; i++) begin
      frame();
      chk("idle_tick", 32'(oFrameTick), 1);
      chk("idle_flapf", 32'(oFlapFrame), 0);
      @(negedge iClk);
      chk("idle_tick_low", 32'(oFrameTick), 0);
    end
    chk("idle_state", 32'(oState), 0);
    chk("idle_scroll", 32'(oScrollX), 6);
    // flap starts the run
    iCountH = 10'd300; iCountV = 10'd200;
    flap_pulse();
    frame();
    chk("start_state", 32'(oState), 1);
    chk("start_flapf", 32'(oFlapFrame), 1);
    chk("start_tick", 32'(oFrameTick), 1);
    chk("start_frames", 32'(oFrames), 0);
    chk("start_scroll", 32'(oScrollX), 8);
    @(negedge iClk);
    chk("start_flapf_low", 32'(oFlapFrame), 0);
    gap_frame();
    frame();
    chk("run2_frames", 32'(oFrames), 2);
    chk("run2_scroll", 32'(oScrollX), 12);
    chk("run2_flapf", 32'(oFlapFrame), 0);
    @(negedge iClk);
    // bird over pipe outside the visible area must not register
    iCountH = 10'd700; iCountV = 10'd100; iDrawBird = 1'b1; iDrawPipe = 1'b1;
    @(negedge iClk);
    iDrawBird = 1'b0; iDrawPipe = 1'b0;
    chk("invis_coll", 32'(oCollision), 0);
    @(negedge iClk);
    // bird not drawn: pipe and ground alone are no hit
    iCountH = 10'd100; iCountV = 10'd100; iDrawPipe = 1'b1; iDrawGround = 1'b1;
    @(negedge iClk);
    iDrawPipe = 1'b0; iDrawGround = 1'b0;
    chk("nobird_coll", 32'(oCollision), 0);
    @(negedge iClk);
    for (int i = 0; i < 313; i++) gap_frame();
    chk("pre_wrap_state", 32'(oState), 1);
    chk("pre_wrap_scroll", 32'(oScrollX), 638);
    chk("pre_wrap_frames", 32'(oFrames), 315);
    frame();
    chk("wrap_scroll", 32'(oScrollX), 0);
    chk("wrap_frames", 32'(oFrames), 316);
    @(negedge iClk);
    gap_frame();
    chk("post_wrap_scroll", 32'(oScrollX), 2);
    // visible bird/ground hit
    iCountH = 10'd100; iCountV = 10'd440; iDrawBird = 1'b1; iDrawGround = 1'b1;
    @(negedge iClk);
    iDrawBird = 1'b0; iDrawGround = 1'b0; iCountH = 10'd101;
    chk("hit_coll", 32'(oCollision), 1);
    @(negedge iClk);
    chk("hit_sticky", 32'(oCollision), 1);
    frame();
    chk("die_state", 32'(oState), 2);
    chk("die_scroll", 32'(oScrollX), 2);
    chk("die_coll", 32'(oCollision), 0);
    chk("die_frames", 32'(oFrames), 317);
    chk("die_flapf", 32'(oFlapFrame), 0);
    @(negedge iClk);
    flap_pulse();
    for (int i = 0; i < 59; i++) gap_frame();
    chk("dying59_state", 32'(oState), 2);
    chk("dying59_scroll", 32'(oScrollX), 2);
    frame();
    chk("over_state", 32'(oState), 3);
    chk("over_flapf", 32'(oFlapFrame), 0);
    @(negedge iClk);
    // flap rising exactly in the end-of-frame sample cycle
    iFlap = 1'b1;
    frame();
    iFlap = 1'b0;
    chk("over_eof_flap_state", 32'(oState), 3);
    chk("over_eof_flap_scroll", 32'(oScrollX), 2);
    @(negedge iClk);
    frame();
    chk("restart_state", 32'(oState), 0);
    chk("restart_scroll", 32'(oScrollX), 0);
    chk("restart_frames", 32'(oFrames), 317);
    @(negedge iClk);
    // back into DYING, then reset asynchronously mid-frame
    flap_pulse();
    gap_frame();
    chk("run_again_state", 32'(oState), 1);
    chk("run_again_frames", 32'(oFrames), 0);
    iCountH = 10'd50; iCountV = 10'd50; iDrawBird = 1'b1; iDrawPipe = 1'b1;
    @(negedge iClk);
    iDrawBird = 1'b0; iDrawPipe = 1'b0;
    gap_frame();
    chk("dying_again_state", 32'(oState), 2);
    iCountH = 10'd60; iCountV = 10'd60; iDrawBird = 1'b1; iDrawGround = 1'b1;
    flap_pulse();
    iDrawBird = 1'b0; iDrawGround = 1'b0;
    #2 iRstN = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);
    frame();
    chk("after_rst_tick", 32'(oFrameTick), 1);
    chk("after_rst_state", 32'(oState), 0);
    chk("after_rst_scroll", 32'(oScrollX), 2);
    @(negedge iClk);
    frame();
    chk("after_rst2_state", 32'(oState), 0);
    chk("after_rst2_scroll", 32'(oScrollX), 4);
    chk("after_rst2_flapf", 32'(oFlapFrame), 0);
    @(negedge iClk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
